e_mdu: RTL
==========

# e_mdu

Execute-stage multiply/divide unit of the P6 pipelined MIPS core. It sits beside the E-stage ALU and takes the same forwarded rs/rt operands. Its read result joins the ALU result in the E-stage result mux feeding the E/M pipeline register. It owns the HI/LO registers, models fixed multi-cycle latency with a busy counter, and tells the hazard unit when D-stage multiply/divide instructions must stall.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset; clears all state immediately on assertion
- a  in  32  forwarded rs value
- b  in  32  forwarded rt value
- md_sel  in  4  operation code: none, mult, multu, div, divu, madd, maddu, msub, msubu, mfhi, mflo, mthi, mtlo. Bubbles carry none.
- md_out  out  32  HI for mfhi, LO for mflo, else 0
- busy  out  1  high while an operation is counting down
- md_hazard  out  1  busy OR a start op present this cycle; the hazard unit stalls a D-stage md-class instruction on this

## Operation
Start ops are mult, multu, div, divu, madd, maddu, msub and msubu.
- A start op with busy=0 is accepted at the rising edge.
  - a and b are latched. The op is latched.
  - The counter loads MULT_CYCLES or DIV_CYCLES and busy rises.
- A start op, mthi or mtlo arriving while busy=1 is ignored. It does not queue, and HI/LO stay unchanged. The hazard unit guarantees this never happens.
- Arithmetic is computed from the latched operands. HI:LO is written at the edge ending the last busy cycle, using the HI:LO value present at that edge.
  - mult/multu: HI:LO = 64-bit product of a×b, signed or unsigned.
  - madd/maddu: HI:LO = HI:LO + product. 64-bit, wraps modulo 2^64.
  - msub/msubu: HI:LO = HI:LO − product. 64-bit, wraps modulo 2^64.
  - div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Division by zero: full busy time elapses, HI/LO unchanged.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- mthi/mtlo with busy=0: HI or LO = a at the same edge (one cycle, no busy).
- mfhi/mflo: md_out is a combinational read of the current HI/LO register and never stalls the E stage. Correctness relies on the D-stage stall via md_hazard.
- State: IDLE ↔ BUSY.
  - IDLE→BUSY on an accepted start op.
  - In BUSY the counter decrements each cycle. BUSY→IDLE when the counter reaches 1, with the commit at that edge.
  - There is no path from BUSY to a new start without passing through IDLE.

## Timing
- Start op in E during cycle T. busy=1 in cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO are updated at the end of T+N and visible on md_out from T+N+1.
- md_hazard = busy | (md_sel is a start op). It is combinational and high in T and in T+1 … T+N.
- mthi/mtlo in cycle T: the new value is visible to mfhi/mflo in T+1.
- Reset values: HI=0, LO=0, busy=0, counter=0, latched op=none, md_out=0.
- Reset asserted mid-operation aborts it. No commit happens, and after release the unit is IDLE with HI=LO=0.
- A start op in the same cycle as reset release is not accepted if reset is still low at that edge.

## Structure
- The op codes (`mdu_none` … `mdu_mtlo`, 4-bit) go in the shared const.v, alongside the ALU select codes.
- The MULT_CYCLES/DIV_CYCLES defaults are also defined in const.v.
- One sub-module is natural: e_mdu_calc, combinational. It takes latched a, b, op and current HI:LO and returns the next {HI, LO} plus a write-enable, with the enable deasserted for divide-by-zero.
- e_mdu keeps the registers, counter, FSM and output mux.

## Test plan
- mult a=0xFFFFFFFE, b=3 → busy for cycles T+1..T+5. md_hazard high in T..T+5. From T+6, HI=0xFFFFFFFF and LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div a=0xFFFFFFF9 (−7), b=2 → after 10 busy cycles LO=0xFFFFFFFD and HI=0xFFFFFFFF. divu a=7, b=0 → 10 busy cycles, HI/LO unchanged.
- mthi 0x1, mtlo 0x0, then msub a=1, b=1 → HI=0x0, LO=0xFFFFFFFF. maddu with a=b=0xFFFFFFFF from HI=LO=0 → HI=0xFFFFFFFE, LO=0x00000001.
- mult issued while busy (forced by the bench) → ignored. The first result commits unchanged and busy ends on schedule. mtlo while busy → ignored.
- reset pulled low during cycle T+3 of a div → busy=0 immediately. HI=LO=0, no later commit. The first start after release is accepted.
- mflo in the cycle after commit (T+N+1) → md_out equals the new LO. mfhi with no prior op after reset → md_out=0.

Source files
------------

// File: rtl/e_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu_pkg
// Description : Shared op codes and latency defaults for the E-stage MDU.
// Revision    : 1.0
// ============================================================================
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MADD  = 4'd5,
        MDU_MADDU = 4'd6,
        MDU_MSUB  = 4'd7,
        MDU_MSUBU = 4'd8,
        MDU_MFHI  = 4'd9,
        MDU_MFLO  = 4'd10,
        MDU_MTHI  = 4'd11,
        MDU_MTLO  = 4'd12
    } mdu_op_e;

    localparam int C_MULT_CYCLES_DEF = 5;
    localparam int C_DIV_CYCLES_DEF  = 10;

    function automatic logic mdu_is_start(input logic [3:0] op);
        return (op >= MDU_MULT) && (op <= MDU_MSUBU);
    endfunction

    function automatic logic mdu_is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu_calc.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu_calc
// Description : Combinational HI:LO result for a latched multiply/divide op.
// Revision    : 1.0
// ============================================================================
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [63:0] hilo_i,
    output logic [63:0] hilo_o,
    output logic        we_o
);

    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic signed [31:0] w_squo;
    logic signed [31:0] w_srem;
    logic               w_sovf;

    always_comb begin
        w_sprod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        w_uprod = {32'd0, a_i} * {32'd0, b_i};
        // -2^31 / -1 overflows 32-bit signed division; pin the architected result
        w_sovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
        w_squo  = 32'sd0;
        w_srem  = 32'sd0;
        if (w_sovf) begin
            w_squo = 32'sh8000_0000;
        end else if (b_i != 32'd0) begin
            w_squo = $signed(a_i) / $signed(b_i);
            w_srem = $signed(a_i) % $signed(b_i);
        end

        hilo_o = hilo_i;
        we_o   = 1'b0;
        case (op_i)
            MDU_MULT:  begin hilo_o = w_sprod;          we_o = 1'b1; end
            MDU_MULTU: begin hilo_o = w_uprod;          we_o = 1'b1; end
            MDU_MADD:  begin hilo_o = hilo_i + w_sprod; we_o = 1'b1; end
            MDU_MADDU: begin hilo_o = hilo_i + w_uprod; we_o = 1'b1; end
            MDU_MSUB:  begin hilo_o = hilo_i - w_sprod; we_o = 1'b1; end
            MDU_MSUBU: begin hilo_o = hilo_i - w_uprod; we_o = 1'b1; end
            MDU_DIV: begin
                hilo_o = {w_srem, w_squo};
                we_o   = (b_i != 32'd0);
            end
            MDU_DIVU: begin
                if (b_i != 32'd0) begin
                    hilo_o = {a_i % b_i, a_i / b_i};
                end
                we_o = (b_i != 32'd0);
            end
            default: begin
                hilo_o = hilo_i;
                we_o   = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu
// Description : E-stage multiply/divide unit: HI/LO, busy counter, hazard out.
// Revision    : 1.0
// ============================================================================
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = C_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = C_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  md_sel,
    output logic [31:0] md_out,
    output logic        busy,
    output logic        md_hazard
);

    localparam int C_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W   = $clog2(C_MAX_CYC + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q,   cnt_d;
    logic [3:0]           op_q,    op_d;
    logic [31:0]          a_q,     a_d;
    logic [31:0]          b_q,     b_d;
    logic [31:0]          hi_q,    hi_d;
    logic [31:0]          lo_q,    lo_d;

    logic [63:0]          w_calc_hilo;
    logic                 w_calc_we;
    logic                 w_start;

    e_mdu_calc u_calc (
        .op_i   (op_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .hilo_i ({hi_q, lo_q}),
        .hilo_o (w_calc_hilo),
        .we_o   (w_calc_we)
    );

    assign w_start = mdu_is_start(md_sel);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_BUSY;
                    op_d    = md_sel;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = mdu_is_div(md_sel) ? C_CNT_W'(DIV_CYCLES)
                                                 : C_CNT_W'(MULT_CYCLES);
                end else if (md_sel == MDU_MTHI) begin
                    hi_d = a;
                end else if (md_sel == MDU_MTLO) begin
                    lo_d = a;
                end
            end
            ST_BUSY: begin
                // Requests arriving here are dropped; the hazard unit prevents them
                if (cnt_q == C_CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    op_d    = MDU_NONE;
                    if (w_calc_we) begin
                        hi_d = w_calc_hilo[63:32];
                        lo_d = w_calc_hilo[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign md_hazard = busy | w_start;

    always_comb begin
        md_out = 32'd0;
        if (md_sel == MDU_MFHI) begin
            md_out = hi_q;
        end else if (md_sel == MDU_MFLO) begin
            md_out = lo_q;
        end
    end

endmodule
`default_nettype wire
